// File: rtl/btns_debounce_pkg.sv
// Shared types, defaults and helpers for the pushbutton conditioning block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package btns_pkg;

  localparam int DEF_N_BTNS          = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;

  // Widest button vector is_onehot() accepts; callers zero-extend into it.
  localparam int MAX_BTNS = 32;

  typedef enum logic {IDLE, WAIT_RELEASE} btn_state_t;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(logic [MAX_BTNS-1:0] v);
    return (v != '0) && ((v & (v - MAX_BTNS'(1))) == '0);
  endfunction

endpackage

// File: rtl/btns_debounce_if.sv
// Button bundle between the raw board pins and the opcode decoder side.
// Latency: none, plain wires.
// Backpressure: none; levels and strobes only.
interface btns_debounce_if import btns_pkg::*; #(
  parameter int N_BTNS = DEF_N_BTNS
);

  logic [N_BTNS-1:0] btns_raw;
  logic [N_BTNS-1:0] btns_clean;
  logic [N_BTNS-1:0] btns_pulse;
  logic [N_BTNS-1:0] btns_sel;

  // Board / stimulus side: drives raw levels, observes conditioned outputs.
  modport master (
    output btns_raw,
    input  btns_clean,
    input  btns_pulse,
    input  btns_sel
  );

  // Conditioning block side.
  modport slave (
    input  btns_raw,
    output btns_clean,
    output btns_pulse,
    output btns_sel
  );

endinterface

// File: rtl/btns_debounce_bit.sv
// Single-button 2-flop synchroniser plus debounce counter and stable level.
// Latency: raw change reaches stable after DEBOUNCE_CYCLES+2 edges.
// Backpressure: none; free-running per clock.
module debounce_bit import btns_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES edges in a row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= sync2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/btns_debounce.sv
// Debounces all buttons and accepts one cleanly pressed button at a time.
// Latency: raw to outputs DEBOUNCE_CYCLES+3 edges.
// Backpressure: none; overlapping presses are dropped until all are released.
module btns_debounce import btns_pkg::*; #(
  parameter int N_BTNS          = DEF_N_BTNS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  btns_debounce_if.slave  bus
);

  logic [N_BTNS-1:0] stable;
  logic [N_BTNS-1:0] clean, clean_nxt;
  logic [N_BTNS-1:0] pulse, pulse_nxt;
  logic [N_BTNS-1:0] sel,   sel_nxt;
  btn_state_t        state, state_nxt;

  for (genvar g = 0; g < N_BTNS; g++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (bus.btns_raw[g]),
      .stable (stable[g])
    );
  end

  // Acceptance FSM: a lone stable press is accepted from IDLE, then nothing
  // new is taken until every button reads released.
  always_comb begin
    state_nxt = state;
    pulse_nxt = '0;
    sel_nxt   = sel;
    clean_nxt = clean;
    case (state)
      IDLE: begin
        if (stable != '0) begin
          state_nxt = WAIT_RELEASE;
          if (is_onehot(MAX_BTNS'(stable))) begin
            pulse_nxt = stable;
            sel_nxt   = stable;
            clean_nxt = stable;
          end else begin
            clean_nxt = '0;
          end
        end
      end
      WAIT_RELEASE: begin
        clean_nxt = clean & stable;
        if (stable == '0) begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pulse <= '0;
      sel   <= '0;
      clean <= '0;
    end else begin
      state <= state_nxt;
      pulse <= pulse_nxt;
      sel   <= sel_nxt;
      clean <= clean_nxt;
    end
  end

  assign bus.btns_clean = clean;
  assign bus.btns_pulse = pulse;
  assign bus.btns_sel   = sel;

endmodule
